// File: rtl/bus_arbiter_pkg.sv
// ============================================================================
// Module : bus_arbiter_pkg
// Brief  : Shared state encoding, field widths and round-robin select helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bus_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int BUS_ARBITER__SIZE_WIDTH = 3;

    // First set bit of req found searching upward from ptr+1, wrapping at n.
    function automatic logic [31:0] rr_select(
        input logic [31:0] req,
        input logic [31:0] ptr,
        input logic [31:0] n
    );
        logic [31:0] cand;
        logic        found;
        rr_select = '0;
        found     = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            cand = (ptr + 32'(k)) % n;
            if ((32'(k) <= n) && !found && req[cand[4:0]]) begin
                rr_select = cand;
                found     = 1'b1;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin pick: one-hot grant, index and any-request.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter int MASTERS = 2,
    parameter int IDX_W   = $clog2(MASTERS)
) (
    input  logic [MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [MASTERS-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    assign o_any = |i_req;
    assign o_idx = IDX_W'(rr_select(32'(i_req), 32'(i_ptr), 32'(MASTERS)));

    for (genvar i = 0; i < MASTERS; i++) begin : g_gnt
        assign o_gnt[i] = o_any && (o_idx == IDX_W'(i));
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module : bus_arbiter
// Brief  : Round-robin arbiter sharing one bus master port, one transaction at
//          a time. Optional watchdog enabled by BUS_ARBITER_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MASTERS        = 2,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [MASTERS-1:0]                     m_req,
    input  logic [MASTERS-1:0]                     m_rd,
    input  logic [MASTERS-1:0]                     m_wr,
    input  logic [MASTERS*WIDTH-1:0]               m_addr,
    input  logic [MASTERS*WIDTH-1:0]               m_wdata,
    input  logic [MASTERS*BUS_ARBITER__SIZE_WIDTH-1:0] m_size,
    output logic [MASTERS-1:0]                     m_grant,
    output logic [MASTERS-1:0]                     m_done,
    output logic                                   m_err,
    output logic [WIDTH-1:0]                       m_rdata,
    output logic                                   bus_rd,
    output logic                                   bus_wr,
    output logic [WIDTH-1:0]                       bus_addr,
    output logic [WIDTH-1:0]                       bus_wdata,
    output logic [BUS_ARBITER__SIZE_WIDTH-1:0]     bus_size,
    input  logic [WIDTH-1:0]                       bus_rdata,
    input  logic                                   bus_done
);

    localparam int IDX_W = $clog2(MASTERS);
    localparam int SW    = BUS_ARBITER__SIZE_WIDTH;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [MASTERS-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    logic [MASTERS-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;

    logic               w_sel_rd;
    logic               w_sel_wr;
    logic [WIDTH-1:0]   w_sel_addr;
    logic [WIDTH-1:0]   w_sel_wdata;
    logic [SW-1:0]      w_sel_size;
    logic               w_busy;
    logic               w_proto_err;
    logic               w_timeout;

    rr_picker #(
        .MASTERS (MASTERS),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .i_req (m_req),
        .i_ptr (ptr_q),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    always_comb begin
        w_sel_rd    = 1'b0;
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_size  = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (sel_q == IDX_W'(i)) begin
                w_sel_rd    = m_rd[i];
                w_sel_wr    = m_wr[i];
                w_sel_addr  = m_addr[i*WIDTH +: WIDTH];
                w_sel_wdata = m_wdata[i*WIDTH +: WIDTH];
                w_sel_size  = m_size[i*SW +: SW];
            end
        end
    end

    assign w_busy      = (state_q == ST_BUSY);
    // Exactly one of rd/wr must be set; anything else never reaches the bus.
    assign w_proto_err = (w_sel_rd == w_sel_wr);

    assign bus_rd    = w_busy && !w_proto_err && w_sel_rd;
    assign bus_wr    = w_busy && !w_proto_err && w_sel_wr;
    assign bus_addr  = w_busy ? w_sel_addr  : '0;
    assign bus_wdata = w_busy ? w_sel_wdata : '0;
    assign bus_size  = w_busy ? w_sel_size  : '0;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!w_busy) begin
            cnt_d = '0;
        end else if (!bus_done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires in the last allowed BUSY cycle; bus_done in that cycle takes priority.
    assign w_timeout = w_busy && !bus_done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    grant_d = w_pick_gnt;
                    sel_d   = w_pick_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_proto_err || bus_done || w_timeout) begin
                    done_d  = grant_q;
                    err_d   = w_proto_err || !bus_done;
                    if (!w_proto_err && bus_done) begin
                        rdata_d = bus_rdata;
                    end
                    ptr_d   = sel_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(MASTERS - 1);
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign m_grant = grant_q;
    assign m_done  = done_q;
    assign m_err   = err_q;
    assign m_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module : tb_bus_arbiter
// Brief  : Directed scoreboard bench for bus_arbiter (2 masters, 32-bit).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    typedef struct packed {
        logic [1:0]  done;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_req, m_rd, m_wr;
    logic [63:0] m_addr, m_wdata;
    logic [5:0]  m_size;
    logic [1:0]  m_grant, m_done;
    logic        m_err;
    logic [31:0] m_rdata;
    logic        bus_rd, bus_wr;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [2:0]  bus_size;
    logic        bus_done;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_rdata;
    int          n_vec;
    int          n_miss;

    bus_arbiter #(
        .MASTERS        (2),
        .WIDTH          (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_req     (m_req),
        .m_rd      (m_rd),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_size    (m_size),
        .m_grant   (m_grant),
        .m_done    (m_done),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_size  (bus_size),
        .bus_rdata (bus_rdata),
        .bus_done  (bus_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int m, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] size);
        m_rd[m]            = rd;
        m_wr[m]            = wr;
        m_addr[m*32 +: 32]  = addr;
        m_wdata[m*32 +: 32] = wdata;
        m_size[m*3 +: 3]    = size;
        m_req[m]           = 1'b1;
    endtask

    task automatic push(input logic [1:0] done, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.done  = done;
        e.err   = err;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic wait_grant(input string name, input logic [1:0] exp);
        int n;
        n = 0;
        tick();
        while (m_grant == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk(name, m_grant, exp);
    endtask

    task automatic finish_bus(input logic [31:0] rdata);
        bus_done  = 1'b1;
        bus_rdata = rdata;
        tick();
        bus_done  = 1'b0;
        last_rdata = rdata;
    endtask

    // Completion monitor: every m_done pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_done != 2'b00) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_done: got m_done=%b, expected no completion", m_done);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("done_mask", 64'(m_done), 64'(mon_e.done));
                        chk("done_err", 64'(m_err), 64'(mon_e.err));
                        chk("done_rdata", 64'(m_rdata), 64'(mon_e.rdata));
                    end
                end else if (m_err) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL err_without_done: got m_err=1, expected 0");
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        last_rdata = '0;
        rst_n      = 1'b0;
        m_req      = '0;
        m_rd       = '0;
        m_wr       = '0;
        m_addr     = '0;
        m_wdata    = '0;
        m_size     = '0;
        bus_rdata  = '0;
        bus_done   = 1'b0;

        repeat (3) tick();
        chk("rst_grant", 64'(m_grant), 64'h0);
        chk("rst_done_err", 64'({m_done, m_err}), 64'h0);
        chk("rst_rdata", 64'(m_rdata), 64'h0);
        chk("rst_bus", 64'({bus_rd, bus_wr, bus_addr}), 64'h0);
        rst_n = 1'b1;
        tick();

        // Single read by master 0
        set_master(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
        push(2'b01, 1'b0, 32'hDEAD_BEEF);
        wait_grant("t1_grant", 2'b01);
        chk("t1_bus_rd", 64'({bus_rd, bus_wr}), 64'b10);
        chk("t1_bus_addr", 64'(bus_addr), 64'h100);
        tick();
        tick();
        finish_bus(32'hDEAD_BEEF);
        m_req = '0;
        chk("t1_bus_idle", 64'({bus_rd, bus_addr}), 64'h0);

        // Both masters requesting continuously: pointer now at 0, so 1 leads
        set_master(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'b010);
        set_master(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            wait_grant("t2_grant", (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("t2_addr", 64'(bus_addr), (i % 2 == 0) ? 64'h300 : 64'h200);
            tick();
            push((i % 2 == 0) ? 2'b10 : 2'b01, 1'b0, 32'hA000_0000 + 32'(i));
            finish_bus(32'hA000_0000 + 32'(i));
            if (i == 3) m_req = '0;
        end

        // Master 1 write, request dropped mid-transaction
        set_master(1, 1'b0, 1'b1, 32'h8000_0000, 32'h1234_5678, 3'b010);
        wait_grant("t3_grant", 2'b10);
        chk("t3_bus_ctl", 64'({bus_rd, bus_wr}), 64'b01);
        chk("t3_bus_addr", 64'(bus_addr), 64'h8000_0000);
        chk("t3_bus_wdata", 64'(bus_wdata), 64'h1234_5678);
        chk("t3_bus_size", 64'(bus_size), 64'b010);
        m_req[1] = 1'b0;
        tick();
        chk("t3_wr_held", 64'(bus_wr), 64'h1);
        push(2'b10, 1'b0, 32'h0BAD_F00D);
        finish_bus(32'h0BAD_F00D);

        // bus_done while idle must be ignored
        bus_done  = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        tick();
        bus_done  = 1'b0;
        tick();
        chk("idle_done_rdata", 64'(m_rdata), 64'(last_rdata));

        // Protocol errors: rd&wr on master 0, neither on master 1
        set_master(0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 3'b000);
        push(2'b01, 1'b1, last_rdata);
        wait_grant("t4_grant", 2'b01);
        chk("t4_no_bus", 64'({bus_rd, bus_wr}), 64'b00);
        tick();
        m_req = '0;
        set_master(1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 3'b000);
        push(2'b10, 1'b1, last_rdata);
        wait_grant("t4b_grant", 2'b10);
        chk("t4b_no_bus", 64'({bus_rd, bus_wr}), 64'b00);
        tick();
        m_req = '0;

        // Reset in the middle of a transaction
        set_master(0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 3'b010);
        wait_grant("t5_grant", 2'b01);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_grant", 64'(m_grant), 64'h0);
        chk("t5_rst_bus", 64'({bus_rd, bus_wr, bus_addr}), 64'h0);
        m_req = '0;
        tick();
        set_master(0, 1'b1, 1'b0, 32'h0000_0610, 32'h0, 3'b010);
        set_master(1, 1'b1, 1'b0, 32'h0000_0620, 32'h0, 3'b010);
        rst_n = 1'b1;
        wait_grant("t5_after_rst", 2'b01);
        push(2'b01, 1'b0, 32'hCAFE_F00D);
        finish_bus(32'hCAFE_F00D);
        m_req = '0;

        // Missing bus_done: watchdog or indefinite wait
        set_master(1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 3'b010);
`ifdef BUS_ARBITER_TIMEOUT_EN
        push(2'b10, 1'b1, last_rdata);
        wait_grant("t6_grant", 2'b10);
        begin
            int busy_cycles;
            busy_cycles = 1;
            for (int k = 0; k < 100; k++) begin
                tick();
                if (m_grant == 2'b00) break;
                busy_cycles++;
            end
            chk("t6_busy_cycles", 64'(busy_cycles), 64'd8);
        end
        m_req = '0;
        bus_done  = 1'b1;
        bus_rdata = 32'h3333_4444;
        tick();
        bus_done  = 1'b0;
        repeat (3) tick();
        chk("t6_late_done_rdata", 64'(m_rdata), 64'(last_rdata));
`else
        wait_grant("t6_grant", 2'b10);
        repeat (1000) tick();
        chk("t6_still_busy", 64'({m_grant, bus_rd}), 64'b101);
        push(2'b10, 1'b0, 32'h1111_2222);
        finish_bus(32'h1111_2222);
        m_req = '0;
`endif

        repeat (5) tick();
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
